// File: rtl/lcd.sv
// Write-only SPI controller for an ILI9341-class TFT: panel reset, fixed init ROM,
// then single host bytes through a LOAD/BUSY handshake, SPI mode 0, MSB first.
module lcd #(
    parameter int CLK_DIV           = 4,
    parameter int RESET_LOW_CYCLES  = 1_000_000,
    parameter int RESET_WAIT_CYCLES = 12_000_000,
    parameter int CMD_DELAY_CYCLES  = 12_000_000
) (
    input  logic       CLK_100MHz,
    input  logic       RESET_N,
    input  logic       LOAD,
    input  logic [7:0] DATA_IN,
    input  logic       IS_CMD,
    output logic       TFT_CS,
    output logic       TFT_RESET,
    output logic       TFT_SDI,
    output logic       TFT_SCK,
    output logic       TFT_DC,
    output logic       BUSY,
    output logic       READY
);

    typedef enum logic [2:0] {
        S_RST_LOW, S_RST_WAIT, S_INIT_SEND, S_INIT_DELAY, S_IDLE, S_SHIFT, S_HOLD
    } state_t;

    typedef enum logic [1:0] {P_START, P_LOW, P_HIGH, P_TAIL} phase_t;

    localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
    localparam logic [31:0] LOW_LAST  = 32'(RESET_LOW_CYCLES - 1);
    localparam logic [31:0] WAIT_LAST = 32'(RESET_WAIT_CYCLES - 1);
    localparam logic [31:0] DLY_LAST  = 32'(CMD_DELAY_CYCLES - 1);
    localparam logic        HAS_DLY   = (CMD_DELAY_CYCLES > 0);

    // Init ROM entry: {delay_after, dc, byte}
    function automatic logic [9:0] rom(input logic [2:0] idx);
        case (idx)
            3'd0:    rom = {HAS_DLY, 1'b0, 8'h01};
            3'd1:    rom = {HAS_DLY, 1'b0, 8'h11};
            3'd2:    rom = {1'b0,    1'b0, 8'h3A};
            3'd3:    rom = {1'b0,    1'b1, 8'h55};
            3'd4:    rom = {1'b0,    1'b0, 8'h29};
            default: rom = 10'd0;
        endcase
    endfunction

    state_t      r_state;
    phase_t      r_ph;
    logic [31:0] r_cnt;
    logic [2:0]  r_idx;
    logic [2:0]  r_bit;
    logic [7:0]  r_sr;
    logic        r_dc_nxt;
    logic        r_dly;
    logic        r_cs;
    logic        r_tft_rst;
    logic        r_sck;
    logic        r_sdi;
    logic        r_dc;
    logic        r_busy;
    logic        r_ready;

    logic [9:0]  w_rom;
    logic        w_gap_ok;

    assign w_rom = rom(r_idx);
    // r_cnt counts CS-high cycles after a byte; the next CS fall may come no
    // earlier than two cycles after the gap check passes, so this keeps gap >= CLK_DIV.
    assign w_gap_ok = (r_cnt + 32'd2 >= 32'(CLK_DIV));

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_RST_LOW;
            r_ph      <= P_START;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_bit     <= '0;
            r_sr      <= '0;
            r_dc_nxt  <= 1'b0;
            r_dly     <= 1'b0;
            r_cs      <= 1'b1;
            r_tft_rst <= 1'b0;
            r_sck     <= 1'b0;
            r_sdi     <= 1'b0;
            r_dc      <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_RST_LOW: begin
                    if (r_cnt == LOW_LAST) begin
                        r_tft_rst <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_RST_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= S_INIT_SEND;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_INIT_SEND: begin
                    if (!w_gap_ok) begin
                        r_cnt <= r_cnt + 32'd1;
                    end else if (r_idx == 3'd5) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_sr     <= w_rom[7:0];
                        r_dc_nxt <= w_rom[8];
                        r_dly    <= w_rom[9];
                        r_idx    <= r_idx + 3'd1;
                        r_ph     <= P_START;
                        r_state  <= S_SHIFT;
                    end
                end
                S_INIT_DELAY: begin
                    if (r_cnt == DLY_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_INIT_SEND;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (LOAD) begin
                        r_sr     <= DATA_IN;
                        r_dc_nxt <= ~IS_CMD;
                        r_busy   <= 1'b1;
                        r_ph     <= P_START;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    case (r_ph)
                        P_START: begin
                            r_cs  <= 1'b0;
                            r_sck <= 1'b0;
                            r_sdi <= r_sr[7];
                            r_dc  <= r_dc_nxt;
                            r_sr  <= {r_sr[6:0], 1'b0};
                            r_cnt <= '0;
                            r_bit <= '0;
                            r_ph  <= P_LOW;
                        end
                        P_LOW: begin
                            if (r_cnt == DIV_LAST) begin
                                r_sck <= 1'b1;
                                r_cnt <= '0;
                                r_ph  <= P_HIGH;
                            end else begin
                                r_cnt <= r_cnt + 32'd1;
                            end
                        end
                        P_HIGH: begin
                            if (r_cnt == DIV_LAST) begin
                                r_sck <= 1'b0;
                                r_cnt <= '0;
                                if (r_bit == 3'd7) begin
                                    r_ph <= P_TAIL;
                                end else begin
                                    // next bit moves only on the SCK falling edge
                                    r_bit <= r_bit + 3'd1;
                                    r_sdi <= r_sr[7];
                                    r_sr  <= {r_sr[6:0], 1'b0};
                                    r_ph  <= P_LOW;
                                end
                            end else begin
                                r_cnt <= r_cnt + 32'd1;
                            end
                        end
                        default: begin
                            if (r_cnt == DIV_LAST) begin
                                r_cs  <= 1'b1;
                                r_cnt <= '0;
                                if (r_ready)    r_state <= S_HOLD;
                                else if (r_dly) r_state <= S_INIT_DELAY;
                                else            r_state <= S_INIT_SEND;
                            end else begin
                                r_cnt <= r_cnt + 32'd1;
                            end
                        end
                    endcase
                end
                S_HOLD: begin
                    if (!w_gap_ok) begin
                        r_cnt <= r_cnt + 32'd1;
                    end else if (!LOAD) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_RST_LOW;
            endcase
        end
    end

    assign TFT_CS    = r_cs;
    assign TFT_RESET = r_tft_rst;
    assign TFT_SDI   = r_sdi;
    assign TFT_SCK   = r_sck;
    assign TFT_DC    = r_dc;
    assign BUSY      = r_busy;
    assign READY     = r_ready;

endmodule

// File: tb/tb_lcd.sv
// Bench for lcd: SPI frames decoded on the bus and scored against a queue of
// expected {dc, byte} pushed when stimulus is driven.
module tb_lcd;

    localparam int D    = 2;
    localparam int RLOW = 10;
    localparam int RWT  = 20;
    localparam int CDLY = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] data_in;
    logic       is_cmd;
    logic       tft_cs, tft_reset, tft_sdi, tft_sck, tft_dc, busy, ready;

    int n_chk  = 0;
    int n_fail = 0;
    int n_frames = 0;
    logic [8:0] q[$];

    typedef struct {
        logic [7:0] data;
        logic       is_cmd;
        int         hold;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl[6];

    lcd #(
        .CLK_DIV(D), .RESET_LOW_CYCLES(RLOW),
        .RESET_WAIT_CYCLES(RWT), .CMD_DELAY_CYCLES(CDLY)
    ) dut (
        .CLK_100MHz(clk), .RESET_N(rst_n), .LOAD(load), .DATA_IN(data_in), .IS_CMD(is_cmd),
        .TFT_CS(tft_cs), .TFT_RESET(tft_reset), .TFT_SDI(tft_sdi), .TFT_SCK(tft_sck),
        .TFT_DC(tft_dc), .BUSY(busy), .READY(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_init();
        q.push_back(9'h001);
        q.push_back(9'h011);
        q.push_back(9'h03A);
        q.push_back(9'h155);
        q.push_back(9'h029);
    endtask

    // Decodes the SPI bus at the falling clock edge and scores each completed frame.
    task automatic monitor();
        logic       prev_cs = 1'b1, prev_sck = 1'b0, prev_sdi = 1'b0;
        logic       in_frame = 1'b0, have_prev = 1'b0, after_dly = 1'b0;
        logic       fdc = 1'b0, bad_sdi = 1'b0, bad_dc = 1'b0;
        logic [7:0] sh = 8'h00;
        logic [8:0] e;
        int         nb = 0, cslow = 0, gap = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cs = 1'b1; prev_sck = 1'b0; prev_sdi = 1'b0;
                in_frame = 1'b0; have_prev = 1'b0; after_dly = 1'b0; gap = 0;
                continue;
            end
            if (prev_cs && !tft_cs) begin
                if (have_prev) begin
                    chk("cs_gap_min", 32'(gap >= D), 32'd1);
                    if (after_dly) chk("init_delay_gap", 32'(gap >= CDLY), 32'd1);
                end
                in_frame = 1'b1; nb = 0; cslow = 0; sh = 8'h00;
                fdc = tft_dc; bad_sdi = 1'b0; bad_dc = 1'b0;
            end
            if (!tft_cs) begin
                cslow++;
                gap = 0;
                if (!prev_sck && tft_sck) begin
                    if (tft_sdi !== prev_sdi) bad_sdi = 1'b1;
                    if (tft_dc !== fdc) bad_dc = 1'b1;
                    sh = {sh[6:0], tft_sdi};
                    nb++;
                end
            end else begin
                gap++;
            end
            if (!prev_cs && tft_cs && in_frame) begin
                in_frame = 1'b0;
                have_prev = 1'b1;
                n_frames++;
                chk("sck_pulses", 32'(nb), 32'd8);
                chk("cs_low_time", 32'(cslow >= 16*D && cslow <= 16*D + 2), 32'd1);
                chk("sdi_dc_stable", 32'({bad_sdi, bad_dc}), 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_frame", 32'({fdc, sh}), 32'h1ff);
                end else begin
                    e = q.pop_front();
                    chk("frame_dc_byte", 32'({fdc, sh}), 32'(e));
                end
                after_dly = !fdc && (sh == 8'h01 || sh == 8'h11);
            end
            prev_cs = tft_cs; prev_sck = tft_sck; prev_sdi = tft_sdi;
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 3000 && !ready; i++) @(negedge clk);
        chk("ready_timeout", 32'(ready), 32'd1);
        chk("busy_after_init", 32'(busy), 32'd0);
        chk("init_queue_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic send(input logic [7:0] d, input logic c, input int hold, input logic [8:0] exp);
        int f0;
        f0 = n_frames;
        q.push_back(exp);
        @(negedge clk);
        data_in = d; is_cmd = c; load = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("cs_fall_sdi_dc", 32'({tft_cs, tft_sdi, tft_dc}), 32'({1'b0, exp[7], exp[8]}));
        data_in = ~d; is_cmd = ~c;
        @(posedge clk); #1;
        chk("sck_low_phase", 32'(tft_sck), 32'd0);
        @(posedge clk); #1;
        chk("sck_first_rise", 32'(tft_sck), 32'd1);
        if (hold == 0) begin
            load = 1'b0;
        end else begin
            repeat (hold) @(negedge clk);
            chk("held_busy", 32'(busy), 32'd1);
            chk("held_one_frame", 32'(n_frames - f0), 32'd1);
            load = 1'b0;
            @(posedge clk); #1;
            chk("busy_fall_after_load", 32'(busy), 32'd0);
        end
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        chk("busy_fall_timeout", 32'(busy), 32'd0);
        chk("cs_high_when_idle", 32'(tft_cs), 32'd1);
        chk("frames_sent", 32'(n_frames - f0), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int rise;
        tbl[0] = '{data: 8'h2A, is_cmd: 1'b1, hold: 0,   exp: 9'h02A};
        tbl[1] = '{data: 8'hA5, is_cmd: 1'b0, hold: 0,   exp: 9'h1A5};
        tbl[2] = '{data: 8'h00, is_cmd: 1'b0, hold: 0,   exp: 9'h100};
        tbl[3] = '{data: 8'hFF, is_cmd: 1'b1, hold: 0,   exp: 9'h0FF};
        tbl[4] = '{data: 8'h81, is_cmd: 1'b0, hold: 100, exp: 9'h181};
        tbl[5] = '{data: 8'h3C, is_cmd: 1'b1, hold: 0,   exp: 9'h03C};

        rst_n = 1'b0; load = 1'b0; data_in = 8'h00; is_cmd = 1'b0;
        fork monitor(); join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({tft_cs, tft_reset, tft_sck, tft_sdi, tft_dc, busy, ready}),
            32'(7'b1000010));

        push_init();
        rst_n = 1'b1;
        rise = 0;
        for (int i = 1; i <= 40 && rise == 0; i++) begin
            @(posedge clk); #1;
            if (tft_reset) rise = i;
        end
        chk("tft_reset_rise_cycle", 32'(rise), 32'(RLOW));

        // LOAD while still initialising must not produce a byte
        repeat (40) @(negedge clk);
        data_in = 8'hEE; is_cmd = 1'b0; load = 1'b1;
        repeat (4) @(negedge clk);
        load = 1'b0;
        wait_ready();
        chk("init_frame_count", 32'(n_frames), 32'd5);

        for (int i = 0; i < 6; i++) send(tbl[i].data, tbl[i].is_cmd, tbl[i].hold, tbl[i].exp);

        // Reset in the middle of a transfer
        q.push_back(9'h0C3);
        @(negedge clk);
        data_in = 8'hC3; is_cmd = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_shift_cs_low", 32'(tft_cs), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({tft_cs, tft_reset, tft_sck, tft_sdi, tft_dc, busy, ready}),
            32'(7'b1000010));
        q.delete();
        rise = n_frames;
        repeat (3) @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_ready();
        chk("reinit_frame_count", 32'(n_frames - rise), 32'd5);
        send(8'h5A, 1'b0, 0, 9'h15A);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
